// File: rtl/gps_ca_signal_gen_if.sv
// gps_ca_signal_gen_if: control and 1-bit ADC sample bundle of the C/A test-signal source
//   start/stop            1-cycle command pulses into the generator
//   sat/code_phase_init   PRN 1..32 and initial chip offset, read at start
//   doppler_omega         signed Doppler NCO step per sample, read at start
//   nav_bit_in            next nav bit, sampled at each bit boundary
//   adc_clk/i/q_sample    sample strobe and 1-bit I/Q samples
//   busy/epoch/chip_index generator status, code-epoch pulse, current chip
//   cfg_err               pulse when start carries an invalid PRN
interface gps_ca_signal_gen_if;
   logic        start;
   logic        stop;
   logic [5:0]  sat;
   logic [9:0]  code_phase_init;
   logic [15:0] doppler_omega;
   logic        nav_bit_in;
   logic        adc_clk;
   logic        i_sample;
   logic        q_sample;
   logic        busy;
   logic        epoch;
   logic [9:0]  chip_index;
   logic        cfg_err;
   modport master (
      output start, stop, sat, code_phase_init, doppler_omega, nav_bit_in,
      input  adc_clk, i_sample, q_sample, busy, epoch, chip_index, cfg_err
   );
   modport slave (
      input  start, stop, sat, code_phase_init, doppler_omega, nav_bit_in,
      output adc_clk, i_sample, q_sample, busy, epoch, chip_index, cfg_err
   );
endinterface

// File: rtl/gps_ca_signal_gen.sv
// gps_ca_signal_gen: GPS L1 C/A baseband source with code-phase offset, Doppler and nav bits
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  gps_ca_signal_gen_if.slave: commands/config in, adc_clk + 1-bit I/Q samples and status out
module gps_ca_signal_gen #(
   parameter int SAMPLE_DIV     = 4,
   parameter int CODE_NCO_OMEGA = 67027,
   parameter int EPOCHS_PER_BIT = 20
) (
   input logic                clk,
   input logic                rst,
   gps_ca_signal_gen_if.slave bus
);
   localparam int DW = $clog2(SAMPLE_DIV);
   localparam int EW = $clog2(EPOCHS_PER_BIT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t        state;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [9:0]    g1, g2, shift_cnt, cpi;
   logic [3:0]    tap1, tap2;
   logic [7:0]    taps;
   logic [17:0]   cphase;
   logic [18:0]   csum;
   logic [15:0]   dphase, dop;
   logic [EW-1:0] epoch_cnt;
   logic          nav, tick, sat_ok, code, lo_i, lo_q, g1_fb, g2_fb, last_epoch, adc_nxt;
   // G2 tap pair {t1,t2} (stage numbers 1..10) for each PRN
   function automatic logic [7:0] prn_taps(input logic [5:0] s);
      case (s)
         6'd1:  prn_taps = 8'h26;
         6'd2:  prn_taps = 8'h37;
         6'd3:  prn_taps = 8'h48;
         6'd4:  prn_taps = 8'h59;
         6'd5:  prn_taps = 8'h19;
         6'd6:  prn_taps = 8'h2A;
         6'd7:  prn_taps = 8'h18;
         6'd8:  prn_taps = 8'h29;
         6'd9:  prn_taps = 8'h3A;
         6'd10: prn_taps = 8'h23;
         6'd11: prn_taps = 8'h34;
         6'd12: prn_taps = 8'h56;
         6'd13: prn_taps = 8'h67;
         6'd14: prn_taps = 8'h78;
         6'd15: prn_taps = 8'h89;
         6'd16: prn_taps = 8'h9A;
         6'd17: prn_taps = 8'h14;
         6'd18: prn_taps = 8'h25;
         6'd19: prn_taps = 8'h36;
         6'd20: prn_taps = 8'h47;
         6'd21: prn_taps = 8'h58;
         6'd22: prn_taps = 8'h69;
         6'd23: prn_taps = 8'h13;
         6'd24: prn_taps = 8'h46;
         6'd25: prn_taps = 8'h57;
         6'd26: prn_taps = 8'h68;
         6'd27: prn_taps = 8'h79;
         6'd28: prn_taps = 8'h8A;
         6'd29: prn_taps = 8'h16;
         6'd30: prn_taps = 8'h27;
         6'd31: prn_taps = 8'h38;
         6'd32: prn_taps = 8'h49;
         default: prn_taps = 8'h00;
      endcase
   endfunction
   always_comb begin
      div_nxt    = (div_cnt == DW'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
      adc_nxt    = div_nxt >= DW'(SAMPLE_DIV / 2);
      tick       = div_cnt == '0;
      sat_ok     = bus.sat != 6'd0 && bus.sat <= 6'd32;
      taps       = prn_taps(bus.sat);
      cpi        = (bus.code_phase_init == 10'd1023) ? 10'd0 : bus.code_phase_init;
      // register bit k holds LFSR stage k+1, so stage 10 is bit 9
      code       = g1[9] ^ g2[tap1 - 4'd1] ^ g2[tap2 - 4'd1];
      // quarter-cycle LO: I = 1100[ph], Q = 0110[ph] with ph = dphase[15:14]
      lo_i       = dphase[15];
      lo_q       = dphase[15] ^ dphase[14];
      g1_fb      = g1[2] ^ g1[9];
      g2_fb      = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
      csum       = {1'b0, cphase} + 19'(CODE_NCO_OMEGA);
      last_epoch = epoch_cnt == EW'(EPOCHS_PER_BIT - 1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         div_cnt        <= '0;
         g1             <= 10'h3FF;
         g2             <= 10'h3FF;
         shift_cnt      <= '0;
         tap1           <= '0;
         tap2           <= '0;
         cphase         <= '0;
         dphase         <= '0;
         dop            <= '0;
         epoch_cnt      <= '0;
         nav            <= 1'b0;
         bus.adc_clk    <= 1'b0;
         bus.i_sample   <= 1'b0;
         bus.q_sample   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.epoch      <= 1'b0;
         bus.chip_index <= '0;
         bus.cfg_err    <= 1'b0;
      end else begin
         div_cnt     <= div_nxt;
         bus.adc_clk <= adc_nxt;
         bus.epoch   <= 1'b0;
         bus.cfg_err <= 1'b0;
         if (bus.stop) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.i_sample <= 1'b0;
            bus.q_sample <= 1'b0;
            epoch_cnt    <= '0;
            nav          <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  bus.i_sample <= 1'b0;
                  bus.q_sample <= 1'b0;
                  if (bus.start && sat_ok) begin
                     tap1           <= taps[7:4];
                     tap2           <= taps[3:0];
                     dop            <= bus.doppler_omega;
                     g1             <= 10'h3FF;
                     g2             <= 10'h3FF;
                     cphase         <= '0;
                     dphase         <= '0;
                     shift_cnt      <= cpi;
                     bus.chip_index <= cpi;
                     bus.busy       <= 1'b1;
                     state          <= LOAD;
                  end else if (bus.start) begin
                     bus.cfg_err <= 1'b1;
                  end
               end
               LOAD: begin
                  // advance the code to the requested chip, one shift per clk;
                  // the final shift and the move to RUN share a cycle
                  if (shift_cnt != 10'd0) begin
                     g1        <= {g1[8:0], g1_fb};
                     g2        <= {g2[8:0], g2_fb};
                     shift_cnt <= shift_cnt - 10'd1;
                  end
                  if (shift_cnt < 10'd2) state <= RUN;
               end
               RUN: begin
                  if (tick) begin
                     bus.i_sample <= code ^ nav ^ lo_i;
                     bus.q_sample <= code ^ nav ^ lo_q;
                     cphase       <= csum[17:0];
                     dphase       <= dphase + dop;
                     if (csum[18] && bus.chip_index == 10'd1022) begin
                        g1             <= 10'h3FF;
                        g2             <= 10'h3FF;
                        bus.chip_index <= '0;
                        bus.epoch      <= 1'b1;
                        epoch_cnt      <= last_epoch ? '0 : epoch_cnt + 1'b1;
                        if (last_epoch) nav <= bus.nav_bit_in;
                     end else if (csum[18]) begin
                        g1             <= {g1[8:0], g1_fb};
                        g2             <= {g2[8:0], g2_fb};
                        bus.chip_index <= bus.chip_index + 10'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gps_ca_signal_gen.sv
// tb_gps_ca_signal_gen: scoreboard bench for the C/A signal source (PRN1 vectors, Doppler, nav, control)
module tb_gps_ca_signal_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [2:0] sbq[$];
   logic [2:0] e;
   logic adc_prev = 1'b0;
   int   n;
   always #5 clk = ~clk;
   gps_ca_signal_gen_if bus();
   gps_ca_signal_gen #(.SAMPLE_DIV(4), .CODE_NCO_OMEGA(67027), .EPOCHS_PER_BIT(2)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   // chips advanced after k samples of the 18-bit code NCO
   function automatic int chip_of(input int k);
      longint p;
      p = longint'(k) * 67027;
      return int'(p >>> 18);
   endfunction
   // entries are {care, i, q}; zeros are the adc_clk rises before the first RUN sample
   task automatic push_run(input int zeros, input int offs, input int lim, input logic dop, input int nav_ep);
      logic [19:0] prn1;
      logic [3:0]  li, lq;
      prn1 = 20'hC8394;
      li = 4'b1100;
      lq = 4'b0110;
      repeat (zeros) sbq.push_back(3'b100);
      for (int k = 0; chip_of(k) + offs < lim; k++) begin
         int   c, m, idx;
         logic nv, b, ei, eq;
         c   = chip_of(k) + offs;
         m   = c % 1023;
         idx = (m < 20) ? 19 - m : 0;
         nv  = nav_ep >= 0 && c / 1023 >= nav_ep;
         b   = prn1[idx];
         ei  = b ^ nv ^ (dop & li[k % 4]);
         eq  = b ^ nv ^ (dop & lq[k % 4]);
         sbq.push_back({m < 20, ei, eq});
      end
   endtask
   always @(negedge clk) begin
      if (bus.adc_clk && !adc_prev && sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e[2]) check("iq_sample", {30'd0, bus.i_sample, bus.q_sample}, {30'd0, e[1:0]});
      end
      adc_prev <= bus.adc_clk;
   end
   task automatic sync_tick();
      int k;
      k = 0;
      while (!bus.adc_clk && k < 20) begin @(negedge clk); k++; end
      while (bus.adc_clk && k < 20) begin @(negedge clk); k++; end
      if (k >= 20) check("sync_timeout", k, 0);
   endtask
   task automatic do_start(input logic [5:0] s, input logic [9:0] p, input logic [15:0] om, input logic also_stop);
      bus.sat = s;
      bus.code_phase_init = p;
      bus.doppler_omega = om;
      bus.start = 1'b1;
      bus.stop = also_stop;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop = 1'b0;
   endtask
   task automatic do_stop();
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("stop_idle", {bus.busy, bus.i_sample, bus.q_sample}, 0);
   endtask
   task automatic drain(input string name);
      int k;
      k = 0;
      while (sbq.size() > 0 && k < 5000) begin @(negedge clk); k++; end
      check(name, sbq.size(), 0);
      sbq.delete();
   endtask
   initial begin
      bus.start = 0; bus.stop = 0; bus.sat = 0; bus.code_phase_init = 0;
      bus.doppler_omega = 0; bus.nav_bit_in = 0;
      @(negedge clk);
      check("reset_outputs", {bus.adc_clk, bus.i_sample, bus.q_sample, bus.busy, bus.epoch,
                              bus.cfg_err, bus.chip_index}, 0);
      @(negedge clk);
      rst = 1'b0;
      // PRN1, nav held 1: two clean epochs, third epoch inverted
      bus.nav_bit_in = 1'b1;
      sync_tick();
      push_run(1, 0, 2066, 1'b0, 2);
      do_start(6'd1, 10'd0, 16'd0, 1'b0);
      n = 1;
      check("busy_run", bus.busy, 1);
      check("start_chip", bus.chip_index, 0);
      while (!bus.epoch && n < 17000) begin @(negedge clk); n++; end
      check("epoch1_time", n, 16005);
      check("epoch1_chip", bus.chip_index, 0);
      @(negedge clk); n++;
      check("epoch_width", bus.epoch, 0);
      while (!bus.epoch && n < 33000) begin @(negedge clk); n++; end
      check("epoch2_time", n, 32009);
      drain("drain_nav");
      do_stop();
      bus.nav_bit_in = 1'b0;
      // code-phase offset 5
      sync_tick();
      push_run(2, 5, 20, 1'b0, -1);
      do_start(6'd1, 10'd5, 16'd0, 1'b0);
      check("load_chip_index", bus.chip_index, 5);
      check("load_busy", bus.busy, 1);
      drain("drain_offset");
      do_stop();
      // quarter-rate Doppler
      sync_tick();
      push_run(1, 0, 20, 1'b1, -1);
      do_start(6'd1, 10'd0, 16'd16384, 1'b0);
      drain("drain_doppler");
      do_stop();
      // invalid PRN
      do_start(6'd0, 10'd0, 16'd0, 1'b0);
      check("cfg_err_sat0", {bus.cfg_err, bus.busy}, 2'b10);
      @(negedge clk);
      check("cfg_err_pulse", bus.cfg_err, 0);
      do_start(6'd33, 10'd0, 16'd0, 1'b0);
      check("cfg_err_sat33", {bus.cfg_err, bus.busy}, 2'b10);
      // start and stop together
      do_start(6'd1, 10'd0, 16'd0, 1'b1);
      check("start_stop_busy", {bus.cfg_err, bus.busy}, 0);
      @(negedge clk);
      check("start_stop_busy2", bus.busy, 0);
      // start while busy is ignored
      do_start(6'd1, 10'd0, 16'd0, 1'b0);
      repeat (10) @(negedge clk);
      do_start(6'd0, 10'd0, 16'd0, 1'b0);
      check("start_while_busy", {bus.cfg_err, bus.busy}, 2'b01);
      do_stop();
      // asynchronous reset mid-run
      do_start(6'd1, 10'd0, 16'd0, 1'b0);
      repeat (60) @(negedge clk);
      check("pre_reset_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1 check("async_reset", {bus.adc_clk, bus.i_sample, bus.q_sample, bus.busy, bus.epoch,
                               bus.cfg_err, bus.chip_index}, 0);
      @(negedge clk);
      rst = 1'b0;
      begin
         logic p;
         int   k;
         p = bus.adc_clk; k = 0;
         do begin p = bus.adc_clk; @(negedge clk); k++; end while (!(bus.adc_clk && !p) && k < 20);
         n = 0;
         do begin p = bus.adc_clk; @(negedge clk); n++; end while (!(bus.adc_clk && !p) && n < 20);
         check("adc_period", n, 4);
      end
      check("post_reset_busy", bus.busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
